mem_ctrl_multi: RTL and testbench

//  Parametrised successor to the two-port IF/MEM memory arbiter. Serialises

---
 rtl/mem_ctrl_multi_pkg.sv | 40 ++++
 rtl/mem_ctrl_multi_if.sv | 29 ++
 rtl/mem_ctrl_multi_arb.sv | 46 ++++
 rtl/mem_ctrl_multi.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl_multi.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_multi_pkg.sv
// Shared definitions for the multi-port byte-serial memory controller:
// size codes, FSM states and byte helpers.
package mem_ctrl_multi_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    RDWAIT = 2'd2
  } CtrlState;

  // Index of the last byte of a transfer; code 11 behaves as a word.
  function automatic logic [1:0] lastByteIdx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SZ_B:    idx = 2'd0;
      SZ_H:    idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] putByte(input logic [31:0] w, input logic [1:0] idx,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] getByte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_multi_if.sv
// Requester and RAM bus bundle of mem_ctrl_multi; the controller uses the
// slave modport, the requesters/RAM side the master modport.
interface mem_ctrl_multi_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32
);
  logic [N_PORTS-1:0]        req_i;
  logic [N_PORTS-1:0]        we_i;
  logic [2*N_PORTS-1:0]      size_i;
  logic [ADDR_W*N_PORTS-1:0] addr_i;
  logic [32*N_PORTS-1:0]     wdata_i;
  logic [7:0]                mem_din_i;
  logic [ADDR_W-1:0]         mem_a_o;
  logic                      mem_wr_o;
  logic [7:0]                mem_dout_o;
  logic [N_PORTS-1:0]        done_o;
  logic [31:0]               rdata_o;
  logic                      busy_o;

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i, mem_din_i,
    output mem_a_o, mem_wr_o, mem_dout_o, done_o, rdata_o, busy_o
  );

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i, mem_din_i,
    input  mem_a_o, mem_wr_o, mem_dout_o, done_o, rdata_o, busy_o
  );
endinterface

// File: rtl/mem_ctrl_multi_arb.sv
// N-way request arbiter: fixed lowest-index priority or round-robin,
// selected by RR_MODE. The round-robin pointer advances only on a taken grant.
module mem_arb
  import mem_ctrl_multi_pkg::*;
#(
  parameter int  N_PORTS = 2,
  parameter int  RR_MODE = 0,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [N_PORTS-1:0] req_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan the ports starting just after the pointer (RR) or at port 0 (fixed).
  always_comb begin
    gnt_idx_o = '0;
    gnt_o     = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (RR_MODE != 0) cand = IDX_W'((int'(ptr_q) + 1 + i) % N_PORTS);
      else              cand = IDX_W'(i);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (found) gnt_o[gnt_idx_o] = 1'b1;
    valid_o = found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr_q <= IDX_W'(N_PORTS - 1);
    else if (en_i && found)    ptr_q <= gnt_idx_o;
  end

endmodule

// File: rtl/mem_ctrl_multi.sv
// Serialises byte/half/word requests from N_PORTS requesters onto a byte-wide
// synchronous RAM and assembles read data little-endian.
module mem_ctrl_multi
  import mem_ctrl_multi_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              rdy,
  mem_ctrl_multi_if.slave  bus
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  CtrlState           state_q, state_d;
  logic [1:0]         cnt_q, cnt_d, lastIdx_q, lastIdx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, memA_q, memA_d;
  logic               we_q, we_d, memWr_q, memWr_d;
  logic [31:0]        wdata_q, wdata_d, asm_q, asm_d, rdata_q, rdata_d;
  logic [7:0]         memDout_q, memDout_d;
  logic [N_PORTS-1:0] owner_q, owner_d, done_q, done_d;
  logic [N_PORTS-1:0] effReq, gnt;
  logic [IDX_W-1:0]   gntIdx;
  logic               gntValid;

  logic [ADDR_W-1:0]  addrArr  [N_PORTS];
  logic [31:0]        wdataArr [N_PORTS];
  logic [1:0]         sizeArr  [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_split
    assign addrArr[p]  = bus.addr_i[p*ADDR_W +: ADDR_W];
    assign wdataArr[p] = bus.wdata_i[p*32 +: 32];
    assign sizeArr[p]  = bus.size_i[p*2 +: 2];
  end

  // A port whose done pulse is showing cannot win again in that same cycle.
  assign effReq = bus.req_i & ~done_q;

  mem_arb #(.N_PORTS(N_PORTS), .RR_MODE(RR_MODE)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (rdy && (state_q == IDLE)),
    .req_i     (effReq),
    .gnt_o     (gnt),
    .gnt_idx_o (gntIdx),
    .valid_o   (gntValid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lastIdx_d = lastIdx_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    memA_d    = memA_q;
    memWr_d   = memWr_q;
    memDout_d = memDout_q;
    asm_d     = asm_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (gntValid) begin
          addr_d    = addrArr[gntIdx];
          we_d      = bus.we_i[gntIdx];
          wdata_d   = wdataArr[gntIdx];
          lastIdx_d = lastByteIdx(sizeArr[gntIdx]);
          owner_d   = gnt;
          cnt_d     = 2'd0;
          asm_d     = ZeroWord;
          memA_d    = addrArr[gntIdx];
          memWr_d   = bus.we_i[gntIdx];
          memDout_d = wdataArr[gntIdx][7:0];
          state_d   = XFER;
        end
      end
      XFER: begin
        // Read data lags the address by one cycle, so byte cnt-1 arrives now.
        if (!we_q && (cnt_q != 2'd0)) asm_d = putByte(asm_q, cnt_q - 2'd1, bus.mem_din_i);
        if (cnt_q != lastIdx_q) begin
          cnt_d     = cnt_q + 2'd1;
          memA_d    = addr_q + ADDR_W'(cnt_d);
          memDout_d = getByte(wdata_q, cnt_d);
        end else if (we_q) begin
          memWr_d = 1'b0;
          done_d  = owner_q;
          state_d = IDLE;
        end else begin
          memA_d  = '0;
          memWr_d = 1'b0;
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        rdata_d = putByte(asm_q, cnt_q, bus.mem_din_i);
        done_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every register freezes while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      lastIdx_q <= 2'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= ZeroWord;
      owner_q   <= '0;
      memA_q    <= '0;
      memWr_q   <= 1'b0;
      memDout_q <= 8'h00;
      asm_q     <= ZeroWord;
      rdata_q   <= ZeroWord;
      done_q    <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lastIdx_q <= lastIdx_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      memA_q    <= memA_d;
      memWr_q   <= memWr_d;
      memDout_q <= memDout_d;
      asm_q     <= asm_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  assign bus.mem_a_o    = memA_q;
  assign bus.mem_wr_o   = memWr_q & rdy;
  assign bus.mem_dout_o = memDout_q;
  assign bus.done_o     = done_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// Bench for mem_ctrl_multi: a fixed-priority 2-port and a round-robin 3-port
// instance, checked against a transaction-level model of latency and arbitration.
module tb_mem_ctrl_multi;

  logic clk, rst_n, rdy, sel;

  mem_ctrl_multi_if #(.N_PORTS(2), .ADDR_W(32)) bus0 ();
  mem_ctrl_multi_if #(.N_PORTS(3), .ADDR_W(32)) bus1 ();

  mem_ctrl_multi #(.N_PORTS(2), .ADDR_W(32), .RR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus0));
  mem_ctrl_multi #(.N_PORTS(3), .ADDR_W(32), .RR_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  reqV, weV;
  logic [1:0]  sizeV  [3];
  logic [31:0] addrV  [3];
  logic [31:0] wdataV [3];
  logic [7:0]  ramDin;

  assign bus0.req_i     = sel ? 2'b00 : reqV[1:0];
  assign bus0.we_i      = weV[1:0];
  assign bus0.size_i    = {sizeV[1], sizeV[0]};
  assign bus0.addr_i    = {addrV[1], addrV[0]};
  assign bus0.wdata_i   = {wdataV[1], wdataV[0]};
  assign bus0.mem_din_i = ramDin;
  assign bus1.req_i     = sel ? reqV : 3'b000;
  assign bus1.we_i      = weV;
  assign bus1.size_i    = {sizeV[2], sizeV[1], sizeV[0]};
  assign bus1.addr_i    = {addrV[2], addrV[1], addrV[0]};
  assign bus1.wdata_i   = {wdataV[2], wdataV[1], wdataV[0]};
  assign bus1.mem_din_i = ramDin;

  wire [31:0] actA     = sel ? bus1.mem_a_o    : bus0.mem_a_o;
  wire        actWr    = sel ? bus1.mem_wr_o   : bus0.mem_wr_o;
  wire [7:0]  actDout  = sel ? bus1.mem_dout_o : bus0.mem_dout_o;
  wire [2:0]  actDone  = sel ? bus1.done_o     : {1'b0, bus0.done_o};
  wire [31:0] actRdata = sel ? bus1.rdata_o    : bus0.rdata_o;
  wire        actBusy  = sel ? bus1.busy_o     : bus0.busy_o;

  // Byte RAM: one-cycle read latency, output register frozen with rdy.
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] expMem [logic [31:0]];

  function automatic logic [7:0] initByte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] ramRead(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : initByte(a);
  endfunction
  function automatic logic [7:0] expRead(input logic [31:0] a);
    return expMem.exists(a) ? expMem[a] : initByte(a);
  endfunction

  always @(posedge clk) begin
    if (rdy) ramDin <= ramRead(actA);
    if (actWr) ram[actA] = actDout;
  end

  int checkCount, errorCount;

  // Transaction model state
  int          nPorts, rrMode, ptr, curPort, curN, rem;
  logic        curWe;
  logic [31:0] curAddr, curWdata, expRdata;
  logic [2:0]  expDone, pending, doneFlag;
  logic        wrChk;
  logic [31:0] wrChkAddr;
  int          wrChkN;
  bit          autoMode;
  int          keepPct, rdyLowPct, rdyLowLeft;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int bytesOf(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic int pickPort(input logic [2:0] eff);
    for (int i = 0; i < nPorts; i++) begin
      int c;
      c = (rrMode != 0) ? (ptr + 1 + i) % nPorts : i;
      if (eff[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    curPort  = -1;
    expDone  = '0;
    expRdata = '0;
    ptr      = nPorts - 1;
    pending  = '0;
    doneFlag = '0;
    reqV     = '0;
    wrChk    = 1'b0;
  endtask

  // Advances the model across one clock edge: a write finishes 1+N cycles
  // after its request was granted, a read 2+N cycles.
  task automatic modelStep();
    logic [2:0] nextDone;
    logic [2:0] eff;
    int g;
    if (!rdy) return;
    nextDone = '0;
    if (curPort < 0) begin
      eff = reqV & ~expDone;
      g = pickPort(eff);
      if (g >= 0) begin
        curPort  = g;
        curWe    = weV[g];
        curN     = bytesOf(sizeV[g]);
        curAddr  = addrV[g];
        curWdata = wdataV[g];
        rem      = curWe ? curN : curN + 1;
        ptr      = g;
      end
    end else begin
      rem--;
      if (rem == 0) begin
        nextDone[curPort] = 1'b1;
        doneFlag[curPort] = 1'b1;
        if (curWe) begin
          for (int k = 0; k < curN; k++) expMem[curAddr + 32'(k)] = curWdata[8*k +: 8];
          wrChk = 1'b1; wrChkAddr = curAddr; wrChkN = curN;
        end else begin
          expRdata = '0;
          for (int k = 0; k < curN; k++) expRdata[8*k +: 8] = expRead(curAddr + 32'(k));
        end
        curPort = -1;
      end
    end
    expDone = nextDone;
  endtask

  task automatic compareOutputs();
    checkOutput("done", 32'(actDone), 32'(expDone));
    checkOutput("busy", 32'(actBusy), 32'(curPort >= 0));
    checkOutput("rdata", actRdata, expRdata);
    checkOutput("memWr", 32'(actWr), 32'(rdy && curPort >= 0 && curWe));
    if (wrChk) begin
      for (int k = 0; k < wrChkN; k++)
        checkOutput("ramByte", 32'(ramRead(wrChkAddr + 32'(k))), 32'(expRead(wrChkAddr + 32'(k))));
      wrChk = 1'b0;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    pending[p] = 1'b1;
    reqV[p]    = 1'b1;
    weV[p]     = we;
    sizeV[p]   = size;
    addrV[p]   = addr;
    wdataV[p]  = data;
  endtask

  task automatic newRandomReq(input int p);
    logic [31:0] a;
    a = ($urandom_range(7) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(2))
                                 : 32'h300 + 32'($urandom_range(63));
    issue(p, 1'($urandom_range(1)), 2'($urandom_range(3)), a, $urandom);
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < nPorts; p++) begin
      if (doneFlag[p]) begin
        doneFlag[p] = 1'b0;
        pending[p]  = 1'b0;
        reqV[p]     = 1'b0;
        if (autoMode && $urandom_range(99) < keepPct) newRandomReq(p);
      end else if (autoMode && !pending[p] && $urandom_range(99) < 30) begin
        newRandomReq(p);
      end
    end
    if (rdyLowLeft > 0) begin
      rdy = 1'b0;
      rdyLowLeft--;
    end else if (autoMode) rdy = ($urandom_range(99) >= rdyLowPct);
    else rdy = 1'b1;
  endtask

  task automatic cycle();
    applyStimulus();
    modelStep();
    @(negedge clk);
    compareOutputs();
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    autoMode = 0;
    while ((pending != 0 || curPort >= 0 || expDone != 0) && n < limit) begin
      cycle();
      n++;
    end
    if (n >= limit) checkOutput("idleTimeout", 32'd1, 32'd0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    rdy   = 1'b1;
    reqV  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "A"}, actA, 32'h0);
    checkOutput({tag, "Wr"}, 32'(actWr), 32'h0);
    checkOutput({tag, "Dout"}, 32'(actDout), 32'h0);
    checkOutput({tag, "Done"}, 32'(actDone), 32'h0);
    checkOutput({tag, "Rdata"}, actRdata, 32'h0);
    checkOutput({tag, "Busy"}, 32'(actBusy), 32'h0);
  endtask

  task automatic randomPhase(input int nCycles, input int keep, input int lowPct);
    autoMode  = 1;
    keepPct   = keep;
    rdyLowPct = lowPct;
    repeat (nCycles) cycle();
    waitIdle(200);
  endtask

  initial begin
    checkCount = 0; errorCount = 0;
    sel = 1'b0; nPorts = 2; rrMode = 0;
    rst_n = 1'b1; rdy = 1'b1; ramDin = 8'h00;
    autoMode = 0; keepPct = 0; rdyLowPct = 0; rdyLowLeft = 0;
    reqV = '0; weV = '0;
    for (int p = 0; p < 3; p++) begin
      sizeV[p] = 2'b00; addrV[p] = '0; wdataV[p] = '0;
    end
    @(negedge clk);
    resetDut();
    checkResetState("rst");

    $display("[TB] word read port 0");
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    expMem[32'h100] = 8'h11; expMem[32'h101] = 8'h22; expMem[32'h102] = 8'h33; expMem[32'h103] = 8'h44;
    issue(0, 1'b0, 2'b10, 32'h100, 32'h0);
    repeat (6) cycle();
    checkOutput("t1done", 32'(actDone), 32'h1);
    checkOutput("t1rdata", actRdata, 32'h4433_2211);
    waitIdle(50);

    $display("[TB] half write port 1");
    issue(1, 1'b1, 2'b01, 32'h200, 32'h0000_BEEF);
    repeat (3) cycle();
    checkOutput("t2done", 32'(actDone), 32'h2);
    cycle();
    checkOutput("t2wrLow", 32'(actWr), 32'h0);
    checkOutput("t2ram0", 32'(ramRead(32'h200)), 32'hEF);
    checkOutput("t2ram1", 32'(ramRead(32'h201)), 32'hBE);
    waitIdle(50);

    $display("[TB] word write with rdy stall");
    issue(0, 1'b1, 2'b10, 32'h400, 32'hCAFE_F00D);
    repeat (2) cycle();
    rdyLowLeft = 3;
    repeat (6) cycle();
    checkOutput("t5done", 32'(actDone), 32'h1);
    checkOutput("t5ram", {ramRead(32'h403), ramRead(32'h402), ramRead(32'h401), ramRead(32'h400)},
                32'hCAFE_F00D);
    waitIdle(50);

    $display("[TB] reset during read wait");
    issue(0, 1'b0, 2'b10, 32'h100, 32'h0);
    repeat (5) cycle();
    checkOutput("t6inWait", 32'(curPort == 0 && rem == 1), 32'h1);
    rst_n = 1'b0;
    #1;
    checkResetState("t6rst");
    @(negedge clk);
    checkOutput("t6noDone", 32'(actDone), 32'h0);
    rst_n = 1'b1;
    modelReset();
    issue(1, 1'b0, 2'b01, 32'h102, 32'h0);
    repeat (4) cycle();
    checkOutput("t6done", 32'(actDone), 32'h2);
    checkOutput("t6rdata", actRdata, 32'h0000_4433);
    waitIdle(50);

    $display("[TB] random traffic, fixed priority");
    randomPhase(800, 50, 10);
    randomPhase(200, 100, 0);

    $display("[TB] random traffic, round robin");
    sel = 1'b1; nPorts = 3; rrMode = 1;
    resetDut();
    checkResetState("rst1");
    randomPhase(800, 50, 10);
    randomPhase(200, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
